// File: rtl/updown_sweep_ctrl.sv
// Triangle sweep sequencer: count runs lo->hi->lo between latched limits, single-shot or continuous.
// Latency: start sampled at edge N gives count=lo and busy=1 after edge N; stop takes effect after one edge.
// Backpressure: none; start is ignored while busy, stop is honoured in every state.
module updown_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] lo_limit,
    input  logic [WIDTH-1:0] hi_limit,
    output logic [WIDTH-1:0] count,
    output logic             upordown,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] lo_q, lo_nxt;
    logic [WIDTH-1:0] hi_q, hi_nxt;
    logic             done_nxt;
    logic             err_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            lo_q  <= lo_nxt;
            hi_q  <= hi_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        lo_nxt    = lo_q;
        hi_nxt    = hi_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        // stop outranks start, so a simultaneous start in IDLE neither launches nor flags err
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (lo_limit < hi_limit) begin
                            lo_nxt    = lo_limit;
                            hi_nxt    = hi_limit;
                            count_nxt = lo_limit;
                            state_nxt = UP;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                UP: begin
                    if (count == hi_q) begin
                        count_nxt = count - WIDTH'(1);
                        state_nxt = DOWN;
                    end else begin
                        count_nxt = count + WIDTH'(1);
                    end
                end
                DOWN: begin
                    if (count != lo_q) begin
                        count_nxt = count - WIDTH'(1);
                    end else if (mode) begin
                        count_nxt = count + WIDTH'(1);
                        state_nxt = UP;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register, so still free of input-to-output paths
    assign busy     = (state != IDLE);
    assign upordown = (state == DOWN);

endmodule
